lsu: RTL and testbench

- Load/store unit: the requester side of the data-memory port.
- Accepts one CPU load/store request at a time (valid/ready) and drives the dmem port: en, per-byte write enables, word address and write data, plus the combinational (asynchronous) read data coming back.
- Splits misaligned accesses into two word accesses.
- Returns sign- or zero-extended load data with a one-cycle response pulse.
- Sits between the core's memory stage and dmem.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_if.sv | 32 +++
 rtl/lsu_align.sv | 46 ++++
 rtl/lsu.sv | 165 ++++++++++++++++
 tb/tb_lsu.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;

    // Access size in bytes; 0 for codes that do not name a width.
    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b10:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Stores have no unsigned variants, loads add LBU/LHU.
    function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
        if (we) begin
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// CPU request/response and dmem signals for the load/store unit.
// master: the LSU itself (it masters the dmem port); slave: core plus dmem.
interface lsu_if #(
    parameter int unsigned AWIDTH = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;
    logic              mem_en;
    logic [3:0]        mem_wbe;
    logic [AWIDTH-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_en, mem_wbe, mem_addr, mem_din
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  mem_en, mem_wbe, mem_addr, mem_din
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane alignment: store enables/data for both word accesses and
// load merge plus sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    input  logic [2:0]  funct3,
    output logic [3:0]  wbe0,
    output logic [3:0]  wbe1,
    output logic [31:0] din0,
    output logic [31:0] din1,
    output logic        split,
    output logic [31:0] ext_rdata
);
    logic [7:0]  mask;
    logic [7:0]  mask_lo;
    logic [7:0]  mask_hi;
    logic [2:0]  rsh;
    logic [31:0] merged;

    // Lane masks, shifted data and extended load result.
    always_comb begin
        mask    = 8'((8'd1 << size) - 8'd1);
        rsh     = 3'd4 - {1'b0, offset};
        mask_lo = mask << offset;
        mask_hi = mask >> rsh;
        wbe0    = mask_lo[3:0];
        wbe1    = mask_hi[3:0];
        din0    = wdata << {offset, 3'b000};
        din1    = (offset == 2'd0) ? 32'd0 : (wdata >> {rsh, 3'b000});
        split   = ({2'b00, offset} + {1'b0, size}) > 4'd4;
        merged  = 32'({hi, lo} >> {offset, 3'b000});
        case (funct3)
            F3_B:    ext_rdata = {{24{merged[7]}}, merged[7:0]};
            F3_H:    ext_rdata = {{16{merged[15]}}, merged[15:0]};
            F3_W:    ext_rdata = merged;
            F3_BU:   ext_rdata = {24'd0, merged[7:0]};
            F3_HU:   ext_rdata = {16'd0, merged[15:0]};
            default: ext_rdata = 32'd0;
        endcase
    end
endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, misaligned accesses split into
// two word accesses, one-cycle response pulse.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 10
) (
    input logic   clk,
    input logic   rst,
    lsu_if.master bus
);
    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [AWIDTH-1:0] widx_q, widx_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [DWIDTH-1:0] lo_q, lo_d;
    logic              err_q, err_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic [AWIDTH-1:0] maddr_q, maddr_d;

    logic              req_ready, resp_valid, resp_err, mem_en;
    logic [3:0]        mem_wbe, wbe0, wbe1;
    logic [AWIDTH-1:0] mem_addr;
    logic [31:0]       mem_din, din0, din1, lo_in, hi_in, ext_rdata;
    logic              split;

    // In ACC1 the low word is already captured and dmem returns the high word.
    assign lo_in = (state_q == ACC1) ? lo_q : bus.mem_dout;
    assign hi_in = (state_q == ACC1) ? bus.mem_dout : 32'd0;

    lsu_align u_align (
        .offset    (off_q),
        .size      (size_of(f3_q)),
        .wdata     (wdata_q),
        .lo        (lo_in),
        .hi        (hi_in),
        .funct3    (f3_q),
        .wbe0      (wbe0),
        .wbe1      (wbe1),
        .din0      (din0),
        .din1      (din1),
        .split     (split),
        .ext_rdata (ext_rdata)
    );

    // Next-state and port outputs; reset masks everything so no write escapes.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        f3_d       = f3_q;
        off_d      = off_q;
        widx_d     = widx_q;
        wdata_d    = wdata_q;
        lo_d       = lo_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        mem_en     = 1'b0;
        mem_wbe    = 4'd0;
        mem_din    = 32'd0;
        mem_addr   = maddr_q;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    f3_d    = bus.req_funct3;
                    off_d   = bus.req_addr[1:0];
                    widx_d  = bus.req_addr[AWIDTH+1:2];
                    wdata_d = bus.req_wdata;
                    if (f3_legal(bus.req_we, bus.req_funct3)) begin
                        err_d   = 1'b0;
                        state_d = ACC0;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end
                end
            end
            ACC0: begin
                mem_en   = 1'b1;
                mem_addr = widx_q;
                if (we_q) begin
                    mem_wbe = wbe0;
                    mem_din = din0;
                end
                lo_d = bus.mem_dout;
                if (split) begin
                    state_d = ACC1;
                end else begin
                    rdata_d = we_q ? '0 : ext_rdata;
                    state_d = RESP;
                end
            end
            ACC1: begin
                mem_en   = 1'b1;
                mem_addr = widx_q + AWIDTH'(1);
                if (we_q) begin
                    mem_wbe = wbe1;
                    mem_din = din1;
                end
                rdata_d = we_q ? '0 : ext_rdata;
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            req_ready  = 1'b0;
            resp_valid = 1'b0;
            resp_err   = 1'b0;
            mem_en     = 1'b0;
            mem_wbe    = 4'd0;
            mem_din    = 32'd0;
            mem_addr   = maddr_q;
        end
        maddr_d = mem_addr;
    end

    // State and request/capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            widx_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            maddr_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            widx_q  <= widx_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            maddr_q <= maddr_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_err   = resp_err;
    assign bus.resp_rdata = rdata_q;
    assign bus.mem_en     = mem_en;
    assign bus.mem_wbe    = mem_wbe;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_din    = mem_din;
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a behavioural 1024-word dmem.
module tb_lsu;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    lsu_if #(.AWIDTH(10)) bus ();

    lsu #(.DWIDTH(32), .AWIDTH(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    assign bus.mem_dout = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wbe[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_din[8*b +: 8];
            end
        end
    end

    // Per-request record of the dmem accesses seen.
    int          acc_n;
    logic [31:0] acc_addr [2];
    logic [31:0] acc_wbe [2];
    logic [31:0] acc_din [2];
    int          lat;
    logic [31:0] r_err;
    logic [31:0] r_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE (called #1 after a posedge) and run to response.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        acc_n  = 0;
        lat    = 0;
        r_err  = 32'hx;
        r_data = 32'hx;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (bus.mem_en && acc_n < 2) begin
                acc_addr[acc_n] = 32'(bus.mem_addr);
                acc_wbe[acc_n]  = 32'(bus.mem_wbe);
                acc_din[acc_n]  = bus.mem_din;
                acc_n++;
            end
            if (bus.resp_valid) begin
                lat    = k;
                r_err  = 32'(bus.resp_err);
                r_data = bus.resp_rdata;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("rst_mem_en", 32'(bus.mem_en), 0);
        chk("rst_rdata", bus.resp_rdata, 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 1);

        // SW aligned
        run_req(1'b1, F3_W, 32'h0, 32'hdeadbeef);
        chk("sw_lat", 32'(lat), 2);
        chk("sw_nacc", 32'(acc_n), 1);
        chk("sw_addr", acc_addr[0], 0);
        chk("sw_wbe", acc_wbe[0], 32'hf);
        chk("sw_din", acc_din[0], 32'hdeadbeef);
        chk("sw_err", r_err, 0);
        chk("sw_rdata", r_data, 0);
        chk("sw_mem0", mem[0], 32'hdeadbeef);

        // SB at byte 5
        run_req(1'b1, F3_B, 32'h5, 32'h000000be);
        chk("sb_wbe", acc_wbe[0], 32'h2);
        chk("sb_din", acc_din[0], 32'h0000be00);
        chk("sb_mem1", mem[1], 32'h0000be00);

        // Loads from word 0
        run_req(1'b0, F3_B, 32'h3, 32'h0);
        chk("lb_rdata", r_data, 32'hffffffde);
        chk("lb_lat", 32'(lat), 2);
        chk("lb_wbe", acc_wbe[0], 0);
        run_req(1'b0, F3_BU, 32'h3, 32'h0);
        chk("lbu_rdata", r_data, 32'h000000de);
        run_req(1'b0, F3_HU, 32'h0, 32'h0);
        chk("lhu_rdata", r_data, 32'h0000beef);
        run_req(1'b0, F3_H, 32'h2, 32'h0);
        chk("lh_rdata", r_data, 32'hffffdead);

        // Split SW at byte 6
        run_req(1'b1, F3_W, 32'h6, 32'h11223344);
        chk("ssw_lat", 32'(lat), 3);
        chk("ssw_nacc", 32'(acc_n), 2);
        chk("ssw_addr0", acc_addr[0], 1);
        chk("ssw_wbe0", acc_wbe[0], 32'hc);
        chk("ssw_din0", acc_din[0], 32'h33440000);
        chk("ssw_addr1", acc_addr[1], 2);
        chk("ssw_wbe1", acc_wbe[1], 32'h3);
        chk("ssw_din1", acc_din[1], 32'h00001122);
        chk("ssw_mem1", mem[1], 32'h3344be00);
        chk("ssw_mem2", mem[2], 32'h00001122);
        run_req(1'b0, F3_W, 32'h6, 32'h0);
        chk("slw_lat", 32'(lat), 3);
        chk("slw_rdata", r_data, 32'h11223344);
        chk("slw_wbe1", acc_wbe[1], 0);

        // SH at the last byte wraps to word 0
        run_req(1'b1, F3_H, 32'(4 * 1023 + 3), 32'h0000abcd);
        chk("wrap_addr0", acc_addr[0], 1023);
        chk("wrap_wbe0", acc_wbe[0], 32'h8);
        chk("wrap_addr1", acc_addr[1], 0);
        chk("wrap_wbe1", acc_wbe[1], 32'h1);
        chk("wrap_mem0", mem[0], 32'hdeadbeab);
        chk("wrap_mem1023", mem[1023], 32'hcd000000);

        // Upper address bits are ignored
        run_req(1'b0, F3_W, 32'h1000_0000, 32'h0);
        chk("hiaddr_rdata", r_data, 32'hdeadbeab);

        // Illegal funct3 load
        run_req(1'b0, 3'b011, 32'h0, 32'h0);
        chk("ill_lat", 32'(lat), 1);
        chk("ill_nacc", 32'(acc_n), 0);
        chk("ill_err", r_err, 1);
        chk("ill_rdata", r_data, 0);

        // Reset during ACC0 of a split store: the ACC1 word must stay untouched
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h9;
        bus.req_wdata  = 32'h55667788;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("mid_acc0_en", 32'(bus.mem_en), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(bus.req_ready), 0);
        @(posedge clk);
        #1;
        chk("mid_rst_en", 32'(bus.mem_en), 0);
        @(posedge clk);
        #1;
        chk("mid_rst_resp", 32'(bus.resp_valid), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_mem3", mem[3], 0);
        chk("mid_ready", 32'(bus.req_ready), 1);
        chk("mid_en", 32'(bus.mem_en), 0);
        run_req(1'b0, F3_W, 32'h0, 32'h0);
        chk("recover_rdata", r_data, 32'hdeadbeab);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
